tile_row_fetcher: RTL and testbench
===================================

TILE_ROW_FETCHER -- requirements
Module: tile_row_fetcher

Interface
REQ-001 SHALL take parameter BDR, default 0: tile code returned for off-map pixels and held after reset.
REQ-002 SHALL take parameter BLOCK_WIDTH, default 40: tile edge in pixels.
REQ-003 SHALL take parameters SCREEN_WIDTH, default 640, and SCREEN_HEIGHT, default 480: visible area.
REQ-004 SHALL take parameters MAP_ROWS, default 12, and MAP_COLS, default 17: tile-map dimensions.
REQ-005 SHALL have port vga_clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port line_start, input, 1 bit: one-cycle pulse requesting a fetch for the upcoming line.
REQ-008 SHALL have port line_y, input, 10 bits: upcoming line number, sampled only when line_start is high.
REQ-009 SHALL have port rd_req, output, 1 bit: tile-map read strobe.
REQ-010 SHALL have ports rd_row, output, 4 bits, and rd_col, output, 5 bits: tile-map read address.
REQ-011 SHALL have port rd_data, input, 3 bits: tile code, valid exactly 1 cycle after rd_req.
REQ-012 SHALL have port pix_x, input, 10 bits: current pixel column.
REQ-013 SHALL have port pix_tile, output, 3 bits: tile code under pix_x on the current line.
REQ-014 SHALL have ports pix_off_x, output, 6 bits, and pix_off_y, output, 6 bits: offsets of the pixel within its tile.
REQ-015 SHALL have port busy, output, 1 bit: high while a fetch is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when the buffers swap.

Function
REQ-017 SHALL hold two MAP_COLS-entry, 3-bit line buffers: front (drives the pixel side) and back (fill target).
REQ-018 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-019 SHALL, in IDLE on line_start with line_y < SCREEN_HEIGHT, latch R = line_y/BLOCK_WIDTH and Y = line_y mod BLOCK_WIDTH, then enter FETCH.
REQ-020 SHALL ignore line_start with line_y >= SCREEN_HEIGHT in every state.
REQ-021 SHALL, in FETCH, assert rd_req for MAP_COLS consecutive cycles with rd_row = MAP_ROWS-1-R and rd_col = MAP_COLS-1-c for c = 0..MAP_COLS-1.
REQ-022 SHALL map the top-left screen tile to map index [MAP_ROWS-1][MAP_COLS-1].
REQ-023 SHALL write rd_data into back[c] one cycle after the request for column c.
REQ-024 SHALL move from FETCH to DRAIN after the request for c = MAP_COLS-1, with rd_req low in DRAIN.
REQ-025 SHALL, in DRAIN, capture the last rd_data, then on the next edge swap front and back, load pix_off_y with Y, pulse done, and return to IDLE.
REQ-026 SHALL make the latency from line_start to done equal to MAP_COLS+2 cycles (19 at defaults).
REQ-027 SHALL, on a valid line_start in FETCH or DRAIN, abort, leave front unchanged, skip the swap and done, and restart FETCH at c = 0 with the new R and Y.
REQ-028 SHALL drive busy high exactly in FETCH and DRAIN.
REQ-029 SHALL register pix_tile with 1-cycle latency as front[pix_x/BLOCK_WIDTH] when pix_x < SCREEN_WIDTH, else BDR.
REQ-030 SHALL register pix_off_x with 1-cycle latency as pix_x mod BLOCK_WIDTH, or 0 when pix_x >= SCREEN_WIDTH.
REQ-031 SHALL compute the divide and modulo by 40 with a comparator chain or lookup, with no generic divider.
REQ-032 SHALL use the new front buffer for the pix_x sampled in the swap cycle.
REQ-033 SHALL require the upstream to issue line_start at least MAP_COLS+2 cycles before the first visible pixel; violations show stale tiles and are not errors.

Reset
REQ-034 SHALL, while reset = 0 and asynchronously, force state IDLE, rd_req 0, rd_row 0, rd_col 0, busy 0 and done 0.
REQ-035 SHALL, while reset = 0, set pix_tile, pix_off_x and pix_off_y to 0 and both buffers entirely to BDR.
REQ-036 SHALL, on reset during FETCH, discard the fetch with no done pulse.
REQ-037 SHALL resume on the first clock edge after reset returns high.

Verification
REQ-038 SHALL cover: reset released, pix_x=100 -> pix_tile=0 (BDR), pix_off_x=0, busy=0.
REQ-039 SHALL cover: line_start with line_y=85 -> R=2, Y=5; rd_row=9, rd_col=16..0 over 17 cycles; done at cycle 19; pix_off_y=5.
REQ-040 SHALL cover: map row 9 = {col16:1, col15:2, rest 1}, after done pix_x=45 -> pix_tile=2, pix_off_x=5 one cycle later.
REQ-041 SHALL cover: line_start line_y=40 and, 8 cycles later, line_start line_y=200 -> the first fetch aborts with no done; rd_row restarts at 6, rd_col at 16; done 19 cycles after the second pulse.
REQ-042 SHALL cover: line_start line_y=480 -> no rd_req and busy stays 0; pix_x=650 -> pix_tile=BDR.
REQ-043 SHALL cover: reset asserted at FETCH cycle 10 -> rd_req and busy drop immediately; front still all BDR after release.

Source files
------------

// File: rtl/tile_row_fetcher.sv
// Fetches one tile-map row per video line into a back buffer, then swaps it to the front
// buffer that drives the per-pixel tile code and in-tile offsets.
module tile_row_fetcher #(
   parameter logic [2:0]  BDR           = 3'd0,
   parameter int unsigned BLOCK_WIDTH   = 40,
   parameter int unsigned SCREEN_WIDTH  = 640,
   parameter int unsigned SCREEN_HEIGHT = 480,
   parameter int unsigned MAP_ROWS      = 12,
   parameter int unsigned MAP_COLS      = 17
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       line_start,
   input  logic [9:0] line_y,
   output logic       rd_req,
   output logic [3:0] rd_row,
   output logic [4:0] rd_col,
   input  logic [2:0] rd_data,
   input  logic [9:0] pix_x,
   output logic [2:0] pix_tile,
   output logic [5:0] pix_off_x,
   output logic [5:0] pix_off_y,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   localparam int unsigned QMAX = 1023 / BLOCK_WIDTH;

   // Quotient by BLOCK_WIDTH as a chain of constant comparisons.
   function automatic logic [5:0] div_bw(input logic [9:0] v);
      logic [5:0] q;
      q = '0;
      for (int unsigned k = 1; k <= QMAX; k++) begin
         if (32'(v) >= k * BLOCK_WIDTH) q = 6'(k);
      end
      return q;
   endfunction

   function automatic logic [5:0] mod_bw(input logic [9:0] v);
      int unsigned rem;
      rem = 32'(v) - 32'(div_bw(v)) * BLOCK_WIDTH;
      return 6'(rem);
   endfunction

   state_t     state, state_n;
   logic [4:0] cnt, cnt_n;
   logic [5:0] y_q, y_n;
   logic       rd_req_n, done_n, busy_n;
   logic [3:0] rd_row_n;
   logic [4:0] rd_col_n;
   logic       start_ok_c, swap_c;

   logic       wr_en_q;
   logic [4:0] wr_idx_q;
   logic       front_sel;
   logic [2:0] buf0 [MAP_COLS];
   logic [2:0] buf1 [MAP_COLS];

   assign start_ok_c = line_start && (32'(line_y) < SCREEN_HEIGHT);

   // State and registered fetch outputs.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         y_q    <= '0;
         rd_req <= 1'b0;
         rd_row <= '0;
         rd_col <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         y_q    <= y_n;
         rd_req <= rd_req_n;
         rd_row <= rd_row_n;
         rd_col <= rd_col_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // A valid line_start always (re)starts the fetch, aborting any fetch in flight.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      y_n      = y_q;
      rd_req_n = 1'b0;
      rd_row_n = rd_row;
      rd_col_n = rd_col;
      done_n   = 1'b0;
      swap_c   = 1'b0;
      if (start_ok_c) begin
         state_n  = FETCH;
         cnt_n    = '0;
         y_n      = mod_bw(line_y);
         rd_req_n = 1'b1;
         rd_row_n = 4'(MAP_ROWS - 1 - 32'(div_bw(line_y)));
         rd_col_n = 5'(MAP_COLS - 1);
      end else begin
         case (state)
            FETCH: begin
               if (cnt == 5'(MAP_COLS - 1)) begin
                  state_n = DRAIN;
                  cnt_n   = '0;
               end else begin
                  cnt_n    = 5'(cnt + 5'd1);
                  rd_req_n = 1'b1;
                  rd_col_n = 5'(rd_col - 5'd1);
               end
            end
            DRAIN: begin
               if (cnt == 5'd0) begin
                  cnt_n = 5'd1;
               end else begin
                  swap_c  = 1'b1;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
            default: ;
         endcase
      end
      busy_n = (state_n != IDLE);
   end

   // Read data lands one cycle after its request; back buffer is the one not selected as front.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         front_sel <= 1'b0;
         for (int i = 0; i < int'(MAP_COLS); i++) begin
            buf0[i] <= BDR;
            buf1[i] <= BDR;
         end
      end else begin
         wr_en_q  <= rd_req;
         wr_idx_q <= cnt;
         if (wr_en_q) begin
            if (front_sel) buf0[wr_idx_q] <= rd_data;
            else           buf1[wr_idx_q] <= rd_data;
         end
         if (swap_c) front_sel <= ~front_sel;
      end
   end

   // Pixel side: in the swap cycle the incoming front buffer is already used.
   logic       pix_vis_c, pix_sel_c;
   logic [4:0] pix_idx_c;
   logic [2:0] tile_c;

   assign pix_vis_c = (32'(pix_x) < SCREEN_WIDTH);
   assign pix_idx_c = 5'(div_bw(pix_x));
   assign pix_sel_c = front_sel ^ swap_c;
   assign tile_c    = pix_sel_c ? buf1[pix_idx_c] : buf0[pix_idx_c];

   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         pix_tile  <= '0;
         pix_off_x <= '0;
         pix_off_y <= '0;
      end else begin
         pix_tile  <= pix_vis_c ? tile_c : BDR;
         pix_off_x <= pix_vis_c ? mod_bw(pix_x) : 6'd0;
         if (swap_c) pix_off_y <= y_q;
      end
   end

endmodule

// File: tb/tb_tile_row_fetcher.sv
// Directed bench for tile_row_fetcher with a one-cycle-latency tile-map model.
module tb_tile_row_fetcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       line_start;
   logic [9:0] line_y;
   logic       rd_req;
   logic [3:0] rd_row;
   logic [4:0] rd_col;
   logic [2:0] rd_data = 3'd0;
   logic [9:0] pix_x;
   logic [2:0] pix_tile;
   logic [5:0] pix_off_x;
   logic [5:0] pix_off_y;
   logic       busy;
   logic       done;

   int tests  = 0;
   int failed = 0;

   tile_row_fetcher dut (
      .vga_clock (clk),
      .reset     (reset),
      .line_start(line_start),
      .line_y    (line_y),
      .rd_req    (rd_req),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_data   (rd_data),
      .pix_x     (pix_x),
      .pix_tile  (pix_tile),
      .pix_off_x (pix_off_x),
      .pix_off_y (pix_off_y),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Row 9 is {col16:1, col15:2, rest 1}; other rows hold (row+col) mod 8.
   function automatic logic [2:0] mem_tile(input logic [3:0] r, input logic [4:0] c);
      if (r == 4'd9) return (c == 5'd15) ? 3'd2 : 3'd1;
      return 3'(32'(r) + 32'(c));
   endfunction

   always @(posedge clk) rd_data <= rd_req ? mem_tile(rd_row, rd_col) : 3'd0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      bit seen_done;
      reset = 1'b0; line_start = 1'b0; line_y = '0; pix_x = 10'd100;
      repeat (3) step();
      chk("rst_rd_req", 32'(rd_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tile", 32'(pix_tile), 0);
      reset = 1'b1;
      chk("rel_off_x", 32'(pix_off_x), 0);
      step();
      chk("rel_tile", 32'(pix_tile), 0);
      chk("rel_off_x100", 32'(pix_off_x), 20);
      chk("rel_busy", 32'(busy), 0);

      // Fetch line 85: R=2 -> row 9, Y=5
      line_start = 1'b1; line_y = 10'd85;
      step();
      line_start = 1'b0;
      chk("f1_req0", 32'(rd_req), 1);
      chk("f1_row0", 32'(rd_row), 9);
      chk("f1_col0", 32'(rd_col), 16);
      chk("f1_busy0", 32'(busy), 1);
      for (int k = 1; k <= 19; k++) begin
         step();
         if (k <= 16) begin
            chk("f1_req", 32'(rd_req), 1);
            chk("f1_col", 32'(rd_col), 32'(16 - k));
            chk("f1_row", 32'(rd_row), 9);
         end else begin
            chk("f1_req_low", 32'(rd_req), 0);
         end
         chk("f1_done", 32'(done), 32'(k == 19));
         chk("f1_busy", 32'(busy), 32'(k < 19));
      end
      chk("f1_off_y", 32'(pix_off_y), 5);
      pix_x = 10'd45;
      step();
      chk("f1_done_drop", 32'(done), 0);
      chk("p45_tile", 32'(pix_tile), 2);
      chk("p45_offx", 32'(pix_off_x), 5);
      pix_x = 10'd0;   step(); chk("p0_tile", 32'(pix_tile), 1);
      chk("p0_offx", 32'(pix_off_x), 0);
      pix_x = 10'd639; step(); chk("p639_tile", 32'(pix_tile), 1);
      chk("p639_offx", 32'(pix_off_x), 39);
      pix_x = 10'd640; step(); chk("p640_tile", 32'(pix_tile), 0);
      chk("p640_offx", 32'(pix_off_x), 0);

      // Abort: line 40 then line 200 eight cycles later
      pix_x = 10'd45;
      line_start = 1'b1; line_y = 10'd40;
      step();
      line_start = 1'b0;
      chk("ab_row10", 32'(rd_row), 10);
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("ab_no_done", 32'(done), 0);
      end
      line_start = 1'b1; line_y = 10'd200;
      step();
      line_start = 1'b0;
      chk("ab_req", 32'(rd_req), 1);
      chk("ab_row6", 32'(rd_row), 6);
      chk("ab_col16", 32'(rd_col), 16);
      for (int k = 1; k <= 19; k++) begin
         step();
         chk("ab_done", 32'(done), 32'(k == 19));
         if (k == 18) begin
            chk("ab_old_front", 32'(pix_tile), 2);
            pix_x = 10'd0;
         end
      end
      chk("ab_swap_tile", 32'(pix_tile), 6);
      chk("ab_off_y", 32'(pix_off_y), 0);
      pix_x = 10'd85;  step(); chk("ab_p85_tile", 32'(pix_tile), 4);
      chk("ab_p85_offx", 32'(pix_off_x), 5);
      pix_x = 10'd600; step(); chk("ab_p600_tile", 32'(pix_tile), 7);

      // Off-screen line is ignored
      line_start = 1'b1; line_y = 10'd480;
      step();
      line_start = 1'b0;
      chk("oob_req", 32'(rd_req), 0);
      chk("oob_busy", 32'(busy), 0);
      pix_x = 10'd650;
      step();
      chk("oob_busy2", 32'(busy), 0);
      chk("p650_tile", 32'(pix_tile), 0);
      chk("p650_offx", 32'(pix_off_x), 0);

      // Reset in the middle of a fetch
      line_start = 1'b1; line_y = 10'd85;
      step();
      line_start = 1'b0;
      repeat (10) step();
      chk("mr_req_pre", 32'(rd_req), 1);
      reset = 1'b0;
      #1;
      chk("mr_req", 32'(rd_req), 0);
      chk("mr_busy", 32'(busy), 0);
      step();
      reset = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 16; k++) begin
         pix_x = 10'(k * 40 + 7);
         step();
         if (done) seen_done = 1'b1;
         chk("mr_front_bdr", 32'(pix_tile), 0);
      end
      repeat (8) begin
         step();
         if (done) seen_done = 1'b1;
      end
      chk("mr_no_done", 32'(seen_done), 0);
      chk("mr_busy_idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
